switch_frame_encoder: RTL and testbench
=======================================

// Module: switch_frame_encoder
// PURPOSE
//  Transmit side of the switch-word protocol consumed by the nibble decoder: takes 8-bit values
//  over a valid/ready handshake and emits each one as two timed 10-bit frames on sw_out.
//  Frame format: sw_out[9:8] = mode, with 00 = low nibble on [3:0], 01 = high nibble on [7:4],
//  and 10 = idle/hold. Used to drive the decoder from logic instead of the physical switches.
// PARAMETERS
//  HOLD_CYCLES  2  clocks each data frame is held on sw_out; legal range 1..255
//  SKIP_ZERO_HI 0  1 = omit the high frame when data[7:4]==0
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst_n       in   1   synchronous reset, active-low
//  in_valid    in   1   in_data is valid
//  in_data     in   8   value to transmit
//  in_ready    out  1   encoder can take in_data this cycle
//  sw_out      out  10  frame word to the decoder (registered)
//  frame_valid out  1   sw_out carries a data frame (mode 00/01)
//  done        out  1   one-cycle pulse when a value's last frame finishes
//  busy        out  1   a value is in flight or pending
// BEHAVIOUR
//  - Reset (rst_n==0 at an edge): state=IDLE, sw_out=10'b10_0000_0000, frame_valid=0, done=0,
//    busy=0, in_ready=1 from the next cycle. Pending entry and hold counter are cleared.
//    A reset mid-frame aborts the transfer with no done pulse.
//  - FSM states: IDLE, SEND_LO, SEND_HI.
//  - Storage: a current register plus one pending register (1-deep skid).
//    in_ready = ~pend_valid (combinational from that register).
//  - Accept rule: a value is taken when in_valid & in_ready at an edge.
//    - In IDLE, the value goes into the current register and the state moves to SEND_LO.
//    - Otherwise the value goes into the pending register.
//  - SEND_LO: sw_out = {2'b00,4'b0000,cur[3:0]}, held HOLD_CYCLES cycles (counter HOLD_CYCLES-1..0).
//    - Then go to SEND_HI.
//    - If SKIP_ZERO_HI=1 and cur[7:4]==0, treat LO as the final frame instead.
//  - SEND_HI: sw_out = {2'b01,cur[7:4],4'b0000}, held HOLD_CYCLES cycles.
//  - Final-frame exit: done pulses in the cycle after the final frame's last hold cycle.
//    - With pend_valid: pending moves to current in the same edge and the FSM goes directly to
//      SEND_LO (no idle frame between values); pend_valid clears, so in_ready rises that cycle.
//    - Without pend_valid: go to IDLE and sw_out = idle word.
//  - Simultaneous events: an accept in the same edge as a pending->current move loads the pending
//    register with the new value; no value is lost or duplicated.
//  - Latency: accept at edge N -> LO frame visible from cycle N+1 -> HI frame from N+1+HOLD_CYCLES.
//    - Throughput: 2*HOLD_CYCLES cycles per value when back-to-back (HOLD_CYCLES when skipped).
//  - frame_valid = 1 in SEND_LO/SEND_HI. busy = (state!=IDLE) | pend_valid.
//  - All outputs are registered except in_ready. Hold counter width is 8 bits; it never wraps.
// STRUCTURE
//  - Shared package sw_proto_pkg (also imported by the decoder):
//    - MODE_LO=2'b00, MODE_HI=2'b01, MODE_IDLE=2'b10;
//    - IDLE_WORD; the frame-field slice localparams.
//  - FSM state encoding stays local. No sub-module is needed; one always block for the FSM and
//    counter, one for the datapath/skid.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles mid-SEND_HI with 8'hA5 -> sw_out=10'h200, done never pulses,
//    in_ready=1.
//  2 Single value, HOLD=2: send 8'h3C -> sw_out 10'h00C for 2 cycles, then 10'h130 for 2 cycles;
//    then done=1 for 1 cycle and sw_out=10'h200.
//  3 Back-to-back 8'h12,8'h34,8'h56 with in_valid held -> in_ready drops after the 2nd accept.
//    Frames 002,110,004,130,006,150 contiguous, 3 done pulses, no idle word between values.
//  4 SKIP_ZERO_HI=1: send 8'h07 -> only 10'h007 for HOLD cycles then done.
//    Send 8'h70 -> 10'h000 then 10'h170.
//  5 HOLD_CYCLES=1, 8'hFF then 8'h00 -> 10'h00F,10'h1F0,10'h000,10'h100 on 4 consecutive
//    cycles, done after 2nd and 4th frames.
//  6 Accept in the same edge as a pending->current move -> the new value is transmitted in order;
//    scoreboard finds no loss or duplicate.

Source files
------------

// File: rtl/sw_proto_pkg.sv
// Shared definitions for the switch-word protocol: mode codes, frame field positions
// and frame builders used by both the encoder and the nibble decoder.
package sw_proto_pkg;

   localparam int FRAME_W  = 10;
   localparam int MODE_MSB = 9;
   localparam int MODE_LSB = 8;
   localparam int HI_MSB   = 7;
   localparam int HI_LSB   = 4;
   localparam int LO_MSB   = 3;
   localparam int LO_LSB   = 0;

   localparam logic [1:0] MODE_LO   = 2'b00;
   localparam logic [1:0] MODE_HI   = 2'b01;
   localparam logic [1:0] MODE_IDLE = 2'b10;

   localparam logic [FRAME_W-1:0] IDLE_WORD = {MODE_IDLE, 8'h00};

   function automatic logic [FRAME_W-1:0] lo_frame(input logic [7:0] value);
      logic [FRAME_W-1:0] f;
      f = '0;
      f[MODE_MSB:MODE_LSB] = MODE_LO;
      f[LO_MSB:LO_LSB]     = value[3:0];
      return f;
   endfunction

   function automatic logic [FRAME_W-1:0] hi_frame(input logic [7:0] value);
      logic [FRAME_W-1:0] f;
      f = '0;
      f[MODE_MSB:MODE_LSB] = MODE_HI;
      f[HI_MSB:HI_LSB]     = value[7:4];
      return f;
   endfunction

endpackage

// File: rtl/switch_frame_encoder.sv
// Transmit side of the switch-word protocol: accepts bytes over valid/ready and plays
// each one out as a timed low-nibble frame followed by a high-nibble frame.
module switch_frame_encoder
   import sw_proto_pkg::*;
#(
   parameter int HOLD_CYCLES  = 2,
   parameter bit SKIP_ZERO_HI = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic [FRAME_W-1:0] sw_out,
   output logic               frame_valid,
   output logic               done,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE,
      SEND_LO,
      SEND_HI
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     state;
   logic [7:0] hold_cnt;
   logic [7:0] cur;
   logic [7:0] pend;
   logic       pend_valid;

   logic       accept;
   logic       last_hold;
   logic       lo_is_final;
   logic       final_exit;
   logic       launch_new;
   logic       launch_pend;
   logic       load_cur;
   logic       to_pend;
   logic       pend_valid_next;
   logic       active_next;
   logic [7:0] next_cur;

   assign in_ready = ~pend_valid;

   // Handshake and sequencing decisions shared by the FSM and the skid datapath.
   always_comb begin
      accept          = in_valid & ~pend_valid;
      last_hold       = (hold_cnt == 8'd0);
      lo_is_final     = SKIP_ZERO_HI && (cur[7:4] == 4'h0);
      final_exit      = last_hold &&
                        ((state == SEND_HI) || ((state == SEND_LO) && lo_is_final));
      launch_new      = (state == IDLE) && accept;
      launch_pend     = pend_valid && ((state == IDLE) || final_exit);
      load_cur        = launch_new | launch_pend;
      next_cur        = launch_pend ? pend : in_data;
      to_pend         = accept && (state != IDLE);
      pend_valid_next = (pend_valid & ~launch_pend) | to_pend;
      active_next     = (state == IDLE) ? load_cur : ~(final_exit & ~load_cur);
   end

   // Frame sequencer: state, hold counter and the registered frame outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         hold_cnt    <= 8'd0;
         sw_out      <= IDLE_WORD;
         frame_valid <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load_cur) begin
                  state       <= SEND_LO;
                  hold_cnt    <= HOLD_LAST;
                  sw_out      <= lo_frame(next_cur);
                  frame_valid <= 1'b1;
               end
            end
            SEND_LO: begin
               if (!last_hold) begin
                  hold_cnt <= hold_cnt - 8'd1;
               end else if (!lo_is_final) begin
                  state    <= SEND_HI;
                  hold_cnt <= HOLD_LAST;
                  sw_out   <= hi_frame(cur);
               end else begin
                  done <= 1'b1;
                  if (load_cur) begin
                     state    <= SEND_LO;
                     hold_cnt <= HOLD_LAST;
                     sw_out   <= lo_frame(next_cur);
                  end else begin
                     state       <= IDLE;
                     hold_cnt    <= 8'd0;
                     sw_out      <= IDLE_WORD;
                     frame_valid <= 1'b0;
                  end
               end
            end
            SEND_HI: begin
               if (!last_hold) begin
                  hold_cnt <= hold_cnt - 8'd1;
               end else begin
                  done <= 1'b1;
                  // A waiting value starts its low frame immediately, with no idle gap.
                  if (load_cur) begin
                     state    <= SEND_LO;
                     hold_cnt <= HOLD_LAST;
                     sw_out   <= lo_frame(next_cur);
                  end else begin
                     state       <= IDLE;
                     hold_cnt    <= 8'd0;
                     sw_out      <= IDLE_WORD;
                     frame_valid <= 1'b0;
                  end
               end
            end
            default: begin
               state       <= IDLE;
               hold_cnt    <= 8'd0;
               sw_out      <= IDLE_WORD;
               frame_valid <= 1'b0;
            end
         endcase
      end
   end

   // Current/pending value registers forming the one-deep skid, plus the busy flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur        <= 8'h00;
         pend       <= 8'h00;
         pend_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         if (load_cur) begin
            cur <= next_cur;
         end
         if (to_pend) begin
            pend <= in_data;
         end
         pend_valid <= pend_valid_next;
         busy       <= active_next | pend_valid_next;
      end
   end

endmodule

// File: tb/tb_switch_frame_encoder.sv
// Directed bench for switch_frame_encoder: three parameterisations share one stimulus
// stream, and each test checks the instance it targets cycle by cycle.
module tb_switch_frame_encoder;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;

   logic       a_ready, s_ready, f_ready;
   logic [9:0] a_sw, s_sw, f_sw;
   logic       a_fv, s_fv, f_fv;
   logic       a_done, s_done, f_done;
   logic       a_busy, s_busy, f_busy;

   int checks = 0;
   int errors = 0;

   localparam int INST_A = 0;
   localparam int INST_S = 1;
   localparam int INST_F = 2;

   switch_frame_encoder #(.HOLD_CYCLES(2), .SKIP_ZERO_HI(1'b0)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(a_ready), .sw_out(a_sw), .frame_valid(a_fv), .done(a_done), .busy(a_busy));

   switch_frame_encoder #(.HOLD_CYCLES(2), .SKIP_ZERO_HI(1'b1)) u_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(s_ready), .sw_out(s_sw), .frame_valid(s_fv), .done(s_done), .busy(s_busy));

   switch_frame_encoder #(.HOLD_CYCLES(1), .SKIP_ZERO_HI(1'b0)) u_f (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(f_ready), .sw_out(f_sw), .frame_valid(f_fv), .done(f_done), .busy(f_busy));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input logic valid, input logic [7:0] data);
      in_valid = valid;
      in_data  = data;
   endtask

   task automatic checkOutput(input string tag, input logic [9:0] observed,
                              input logic [9:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] swOf(input int inst);
      case (inst)
         INST_A:  return a_sw;
         INST_S:  return s_sw;
         default: return f_sw;
      endcase
   endfunction

   function automatic logic doneOf(input int inst);
      case (inst)
         INST_A:  return a_done;
         INST_S:  return s_done;
         default: return f_done;
      endcase
   endfunction

   task automatic stepCheck(input int inst, input string tag, input logic [9:0] exp_sw,
                            input logic exp_done);
      step();
      checkOutput({tag, ".sw_out"}, swOf(inst), exp_sw);
      checkOutput({tag, ".done"}, {9'd0, doneOf(inst)}, {9'd0, exp_done});
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      applyStimulus(1'b0, 8'h00);
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 8'h00);

      // Reset values
      doReset();
      checkOutput("rst.sw_out", a_sw, 10'h200);
      checkOutput("rst.fv", {9'd0, a_fv}, 10'd0);
      checkOutput("rst.done", {9'd0, a_done}, 10'd0);
      checkOutput("rst.busy", {9'd0, a_busy}, 10'd0);
      checkOutput("rst.ready", {9'd0, a_ready}, 10'd1);

      // Test 2: single value 3C, HOLD=2
      $display("[TB] single value");
      applyStimulus(1'b1, 8'h3C);
      stepCheck(INST_A, "t2.e0", 10'h00C, 1'b0);
      checkOutput("t2.fv", {9'd0, a_fv}, 10'd1);
      checkOutput("t2.busy", {9'd0, a_busy}, 10'd1);
      checkOutput("t2.ready", {9'd0, a_ready}, 10'd1);
      applyStimulus(1'b0, 8'h00);
      stepCheck(INST_A, "t2.e1", 10'h00C, 1'b0);
      stepCheck(INST_A, "t2.e2", 10'h130, 1'b0);
      stepCheck(INST_A, "t2.e3", 10'h130, 1'b0);
      stepCheck(INST_A, "t2.e4", 10'h200, 1'b1);
      checkOutput("t2.fv_end", {9'd0, a_fv}, 10'd0);
      checkOutput("t2.busy_end", {9'd0, a_busy}, 10'd0);
      stepCheck(INST_A, "t2.e5", 10'h200, 1'b0);

      // Test 1: reset mid SEND_HI aborts without a done pulse
      $display("[TB] reset mid-frame");
      applyStimulus(1'b1, 8'hA5);
      stepCheck(INST_A, "t1.e0", 10'h005, 1'b0);
      applyStimulus(1'b0, 8'h00);
      stepCheck(INST_A, "t1.e1", 10'h005, 1'b0);
      stepCheck(INST_A, "t1.e2", 10'h1A0, 1'b0);
      rst_n = 1'b0;
      stepCheck(INST_A, "t1.r0", 10'h200, 1'b0);
      stepCheck(INST_A, "t1.r1", 10'h200, 1'b0);
      stepCheck(INST_A, "t1.r2", 10'h200, 1'b0);
      rst_n = 1'b1;
      checkOutput("t1.ready", {9'd0, a_ready}, 10'd1);
      checkOutput("t1.busy", {9'd0, a_busy}, 10'd0);
      stepCheck(INST_A, "t1.post", 10'h200, 1'b0);

      // Test 3: back-to-back 12, 34, 56 with valid held
      $display("[TB] back-to-back");
      doReset();
      applyStimulus(1'b1, 8'h12);
      stepCheck(INST_A, "t3.e0", 10'h002, 1'b0);
      checkOutput("t3.ready0", {9'd0, a_ready}, 10'd1);
      applyStimulus(1'b1, 8'h34);
      stepCheck(INST_A, "t3.e1", 10'h002, 1'b0);
      checkOutput("t3.ready1", {9'd0, a_ready}, 10'd0);
      applyStimulus(1'b1, 8'h56);
      stepCheck(INST_A, "t3.e2", 10'h110, 1'b0);
      stepCheck(INST_A, "t3.e3", 10'h110, 1'b0);
      stepCheck(INST_A, "t3.e4", 10'h004, 1'b1);
      checkOutput("t3.ready4", {9'd0, a_ready}, 10'd1);
      stepCheck(INST_A, "t3.e5", 10'h004, 1'b0);
      checkOutput("t3.ready5", {9'd0, a_ready}, 10'd0);
      applyStimulus(1'b0, 8'h00);
      stepCheck(INST_A, "t3.e6", 10'h130, 1'b0);
      stepCheck(INST_A, "t3.e7", 10'h130, 1'b0);
      stepCheck(INST_A, "t3.e8", 10'h006, 1'b1);
      stepCheck(INST_A, "t3.e9", 10'h006, 1'b0);
      stepCheck(INST_A, "t3.e10", 10'h150, 1'b0);
      stepCheck(INST_A, "t3.e11", 10'h150, 1'b0);
      stepCheck(INST_A, "t3.e12", 10'h200, 1'b1);
      checkOutput("t3.busy_end", {9'd0, a_busy}, 10'd0);

      // Test 4: skip empty high nibble
      $display("[TB] skip zero high");
      doReset();
      applyStimulus(1'b1, 8'h07);
      stepCheck(INST_S, "t4a.e0", 10'h007, 1'b0);
      applyStimulus(1'b0, 8'h00);
      stepCheck(INST_S, "t4a.e1", 10'h007, 1'b0);
      stepCheck(INST_S, "t4a.e2", 10'h200, 1'b1);
      applyStimulus(1'b1, 8'h70);
      stepCheck(INST_S, "t4b.e0", 10'h000, 1'b0);
      applyStimulus(1'b0, 8'h00);
      stepCheck(INST_S, "t4b.e1", 10'h000, 1'b0);
      stepCheck(INST_S, "t4b.e2", 10'h170, 1'b0);
      stepCheck(INST_S, "t4b.e3", 10'h170, 1'b0);
      stepCheck(INST_S, "t4b.e4", 10'h200, 1'b1);

      // Test 5: HOLD=1, FF then 00
      $display("[TB] hold of one");
      doReset();
      applyStimulus(1'b1, 8'hFF);
      stepCheck(INST_F, "t5.e0", 10'h00F, 1'b0);
      applyStimulus(1'b1, 8'h00);
      stepCheck(INST_F, "t5.e1", 10'h1F0, 1'b0);
      checkOutput("t5.ready1", {9'd0, f_ready}, 10'd0);
      applyStimulus(1'b0, 8'h00);
      stepCheck(INST_F, "t5.e2", 10'h000, 1'b1);
      stepCheck(INST_F, "t5.e3", 10'h100, 1'b0);
      stepCheck(INST_F, "t5.e4", 10'h200, 1'b1);
      checkOutput("t5.busy_end", {9'd0, f_busy}, 10'd0);

      // Test 6: a value accepted on the final-frame exit edge is still transmitted
      $display("[TB] accept on exit edge");
      doReset();
      applyStimulus(1'b1, 8'h9A);
      stepCheck(INST_A, "t6.e0", 10'h00A, 1'b0);
      applyStimulus(1'b0, 8'h00);
      stepCheck(INST_A, "t6.e1", 10'h00A, 1'b0);
      stepCheck(INST_A, "t6.e2", 10'h190, 1'b0);
      stepCheck(INST_A, "t6.e3", 10'h190, 1'b0);
      applyStimulus(1'b1, 8'hDE);
      stepCheck(INST_A, "t6.e4", 10'h200, 1'b1);
      checkOutput("t6.busy4", {9'd0, a_busy}, 10'd1);
      checkOutput("t6.ready4", {9'd0, a_ready}, 10'd0);
      applyStimulus(1'b0, 8'h00);
      stepCheck(INST_A, "t6.e5", 10'h00E, 1'b0);
      checkOutput("t6.ready5", {9'd0, a_ready}, 10'd1);
      stepCheck(INST_A, "t6.e6", 10'h00E, 1'b0);
      stepCheck(INST_A, "t6.e7", 10'h1D0, 1'b0);
      stepCheck(INST_A, "t6.e8", 10'h1D0, 1'b0);
      stepCheck(INST_A, "t6.e9", 10'h200, 1'b1);
      stepCheck(INST_A, "t6.e10", 10'h200, 1'b0);
      checkOutput("t6.busy_end", {9'd0, a_busy}, 10'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
